step_clock_gen: RTL
===================

Name: step_clock_gen

Overview:
Tempo source for the sequencer: converts a BPM setting into a train of one-Clock-wide Step pulses and a 4-bit step index (16-step pattern). Sits directly upstream of the loop counter, driving its Step input and consuming its Play output to know when to stop. Uses a phase accumulator, so there is no runtime divider and the long-term tempo is exact.

Parameters:
CLK_HZ, 50000000, Clock frequency in Hz.
STEPS_PER_BEAT, 4, steps per quarter-note beat.
MIN_BPM, 40, lower clamp for Bpm.
MAX_BPM, 240, upper clamp for Bpm.

Ports:
Clock  input  1  system clock, rising edge.
nReset  input  1  asynchronous active-low reset.
nStart  input  1  active-low start request, asynchronous to Clock.
Play  input  1  run-enable from the loop counter, asynchronous to Clock.
Bpm  input  8  tempo in beats per minute, unsigned.
Step  output  1  one-Clock-wide step pulse.
StepIndex  output  4  index of the current step, 0..15.
Beat  output  1  one-Clock pulse coincident with Step when StepIndex mod STEPS_PER_BEAT == 0.
Running  output  1  high while the state is RUN.

Behaviour:
- Reset (nReset low, asynchronous): state IDLE; Step=0, Beat=0, Running=0, StepIndex=0, accumulator=0, synchronisers cleared.
- nStart and Play each pass through a 2-flop synchroniser. A start event is a falling edge of synchronised nStart.
- MOD = CLK_HZ*60, computed at elaboration. The accumulator is 32 bits wide, and MOD must be < 2^32.
- INC = clamp(BpmLatched, MIN_BPM, MAX_BPM) * STEPS_PER_BEAT. Bpm=0 uses MIN_BPM; Bpm>MAX_BPM uses MAX_BPM.
- States:
  - IDLE: outputs idle. A start event moves to RUN.
  - RUN, on the entry cycle: acc=0, StepIndex=0, Step=1, Beat=1, BpmLatched=Bpm.
  - RUN, every later cycle: if acc+INC >= MOD, then acc = acc+INC-MOD, Step=1, StepIndex increments modulo 16 (15 wraps to 0), Beat per its rule, and BpmLatched=Bpm. Otherwise acc = acc+INC and Step=0.
- Bpm changes take effect only at step boundaries.
- Step period is MOD/INC cycles on average; individual periods are floor or ceil of that value.
- StepIndex changes in the same cycle that Step asserts and holds between pulses.
- Stop: in RUN, synchronised Play low moves the state to IDLE on the next edge. StepIndex returns to 0 and no further Step pulses are emitted. Play is ignored on the RUN entry cycle and the following 2 cycles, which covers synchroniser latency after the loop counter raises Play.
- A start event while in RUN restarts the sequence: same actions as RUN entry.
- A start event and Play low in the same cycle: the start event wins.
- Start latency: 3 Clock edges from the nStart falling edge to the first Step pulse (2 synchroniser flops plus the edge detect).
- Stop latency: 3 Clock edges from Play falling to Running low.
- nReset asserted mid-step: immediate return to the reset values. The next start event begins again at StepIndex 0.

Optional Feature:
GATE_OUT_EN:
- Defined: adds output Gate (1 bit). Gate is high while Running and acc < MOD/2, giving a ~50% duty note gate per step. Gate is 0 in IDLE and at reset.
- Undefined: the Gate port and its logic are absent.

Test Plan:
- CLK_HZ=1000, STEPS_PER_BEAT=4, Bpm=60 (MOD=60000, INC=240), nStart pulsed low, Play held high -> first Step 3 cycles after the nStart fall, then Step exactly every 250 cycles. StepIndex runs 0..15 then wraps to 0. Beat fires at indices 0, 4, 8, 12.
- Same setup, Bpm=0, then Bpm=255 -> step period 375 cycles (clamped to 40 BPM), then ~62.5 cycles (clamped to 240 BPM, alternating 62/63). The new tempo applies only after the next Step.
- Running mid-pattern, Play dropped at StepIndex=5 -> Running=0 within 3 cycles, StepIndex=0, and no Step pulses for the following 1000 cycles.
- Running at StepIndex=9, new nStart pulse -> Step with StepIndex=0 3 cycles later, then a full 250-cycle period to StepIndex=1.
- nReset pulsed low for 1 cycle during RUN -> all outputs 0 immediately and the block stays IDLE until the next nStart.
- With GATE_OUT_EN, Bpm=60 -> Gate high for 125 cycles and low for 125 cycles each step. Gate is 0 while IDLE.

Source files
------------

// File: rtl/step_clock_gen.sv
// Step clock generator: BPM to 16-step pulse train via a phase accumulator.
// Optional Gate output (~50% duty per step) when GATE_OUT_EN is defined.
module step_clock_gen #(
    parameter int CLK_HZ         = 50000000,
    parameter int STEPS_PER_BEAT = 4,
    parameter int MIN_BPM        = 40,
    parameter int MAX_BPM        = 240
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       nStart,
    input  logic       Play,
    input  logic [7:0] Bpm,
    output logic       Step,
    output logic [3:0] StepIndex,
    output logic       Beat,
    output logic       Running
`ifdef GATE_OUT_EN
    ,
    output logic       Gate
`endif
);

    // One minute of clock cycles; must stay below 2^32 for the 32-bit accumulator.
    localparam longint     MOD_L = longint'(CLK_HZ) * 64'sd60;
    localparam logic [32:0] MOD  = 33'(MOD_L);
    localparam logic [32:0] HALF = MOD >> 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic        nstart_s1_q, nstart_s2_q, nstart_s3_q;
    logic        play_s1_q, play_s2_q;
    logic [31:0] acc_q;
    logic [3:0]  idx_q;
    logic        step_q, beat_q;
    logic [7:0]  bpm_q;
    logic [1:0]  hold_q;

    logic [7:0]  bpm_clamped_d;
    logic [32:0] inc_d;
    logic [32:0] sum_d;
    logic [3:0]  next_idx_d;
    logic        beat_hit_d;
    logic        start_evt_d;

    always_comb begin
        bpm_clamped_d = bpm_q;
        if (bpm_q < 8'(MIN_BPM)) begin
            bpm_clamped_d = 8'(MIN_BPM);
        end else if (bpm_q > 8'(MAX_BPM)) begin
            bpm_clamped_d = 8'(MAX_BPM);
        end
    end

    assign inc_d       = 33'(bpm_clamped_d) * 33'(STEPS_PER_BEAT);
    assign sum_d       = {1'b0, acc_q} + inc_d;
    assign next_idx_d  = idx_q + 4'd1;
    assign beat_hit_d  = (({28'd0, next_idx_d} % 32'(STEPS_PER_BEAT)) == 32'd0);
    assign start_evt_d = nstart_s3_q & ~nstart_s2_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            nstart_s1_q <= 1'b0;
            nstart_s2_q <= 1'b0;
            nstart_s3_q <= 1'b0;
            play_s1_q   <= 1'b0;
            play_s2_q   <= 1'b0;
            acc_q       <= 32'd0;
            idx_q       <= 4'd0;
            step_q      <= 1'b0;
            beat_q      <= 1'b0;
            bpm_q       <= 8'd0;
            hold_q      <= 2'd0;
        end else begin
            nstart_s1_q <= nStart;
            nstart_s2_q <= nstart_s1_q;
            nstart_s3_q <= nstart_s2_q;
            play_s1_q   <= Play;
            play_s2_q   <= play_s1_q;
            step_q      <= 1'b0;
            beat_q      <= 1'b0;
            if (start_evt_d) begin
                // Entry and restart share one path; a start beats a concurrent stop.
                state_q <= RUN;
                acc_q   <= 32'd0;
                idx_q   <= 4'd0;
                step_q  <= 1'b1;
                beat_q  <= 1'b1;
                bpm_q   <= Bpm;
                hold_q  <= 2'd3;
            end else if (state_q == RUN) begin
                if (hold_q != 2'd0) begin
                    hold_q <= hold_q - 2'd1;
                end
                if ((hold_q == 2'd0) && !play_s2_q) begin
                    state_q <= IDLE;
                    acc_q   <= 32'd0;
                    idx_q   <= 4'd0;
                end else if (sum_d >= MOD) begin
                    acc_q  <= 32'(sum_d - MOD);
                    idx_q  <= next_idx_d;
                    step_q <= 1'b1;
                    beat_q <= beat_hit_d;
                    bpm_q  <= Bpm;
                end else begin
                    acc_q <= sum_d[31:0];
                end
            end
        end
    end

    assign Step      = step_q;
    assign StepIndex = idx_q;
    assign Beat      = beat_q;
    assign Running   = (state_q == RUN);

`ifdef GATE_OUT_EN
    assign Gate = Running && ({1'b0, acc_q} < HALF);
`endif

endmodule
